// File: rtl/decode_stage_buf.sv
// Decode stage between fetch and execute: classifies 32-bit MIPS-style instructions, flags load-use
// hazards and buffers decoded entries in a DEPTH-deep FIFO. Optional illegal-op trap: DECODE_TRAP_EN.
module decode_stage_buf #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_class,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_wr_reg,
    output logic              out_wr_en,
    output logic [DATA_W-1:0] out_imm,
    output logic [5:0]        out_funct,
`ifdef DECODE_TRAP_EN
    output logic              illegal_trap,
`endif
    output logic              out_load_use
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [3:0] CLS_RALU = 4'b0000;
    localparam logic [3:0] CLS_ADDI = 4'b0001;
    localparam logic [3:0] CLS_LW   = 4'b0011;
    localparam logic [3:0] CLS_SW   = 4'b0100;
    localparam logic [3:0] CLS_BR   = 4'b0101;
    localparam logic [3:0] CLS_J    = 4'b0110;
    localparam logic [3:0] CLS_ILL  = 4'b1111;

    typedef struct packed {
        logic [3:0]        cls;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wr_reg;
        logic              wr_en;
        logic [DATA_W-1:0] imm;
        logic [5:0]        funct;
        logic              load_use;
    } entry_t;

    entry_t            slots_r [DEPTH];
    entry_t            dec_s;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              last_ld_v_r;
    logic [REG_AW-1:0] last_ld_reg_r;
    logic              trap_r;
    logic              push_s;
    logic              pop_s;
    logic              uses_rt_s;
    logic [REG_AW-1:0] rd_s;
    logic              unused_shamt;

    assign unused_shamt = ^in_instr[10:6];

`ifdef DECODE_TRAP_EN
    assign in_ready     = (count_r < DEPTH_C) && !trap_r;
    assign illegal_trap = trap_r;
`else
    assign in_ready     = (count_r < DEPTH_C);
`endif
    assign out_valid = (count_r != {CW{1'b0}});
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign rd_s      = REG_AW'(in_instr[15:11]);

    // Decode the incoming word into a buffer entry, including hazard check against the last load
    always_comb begin
        dec_s        = '0;
        dec_s.rs     = REG_AW'(in_instr[25:21]);
        dec_s.rt     = REG_AW'(in_instr[20:16]);
        dec_s.imm    = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
        dec_s.funct  = in_instr[5:0];
        case (in_instr[31:26])
            6'b000000: begin dec_s.cls = CLS_RALU; dec_s.wr_reg = rd_s;     end
            6'b001000: begin dec_s.cls = CLS_ADDI; dec_s.wr_reg = dec_s.rt; end
            6'b100011: begin dec_s.cls = CLS_LW;   dec_s.wr_reg = dec_s.rt; end
            6'b101011: begin dec_s.cls = CLS_SW;   dec_s.wr_reg = '0;       end
            6'b000100,
            6'b000101: begin dec_s.cls = CLS_BR;   dec_s.wr_reg = '0;       end
            6'b000010: begin dec_s.cls = CLS_J;    dec_s.wr_reg = '0;       end
            default:   begin dec_s.cls = CLS_ILL;  dec_s.wr_reg = '0;       end
        endcase
        dec_s.wr_en = (dec_s.wr_reg != {REG_AW{1'b0}});
        uses_rt_s   = (dec_s.cls == CLS_RALU) || (dec_s.cls == CLS_SW) || (dec_s.cls == CLS_BR);
        if (last_ld_v_r && (dec_s.cls != CLS_J)) begin
            dec_s.load_use = (dec_s.rs == last_ld_reg_r) ||
                             (uses_rt_s && (dec_s.rt == last_ld_reg_r));
        end else begin
            dec_s.load_use = 1'b0;
        end
    end

    // FIFO storage, pointers, occupancy, load tracking and trap state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '0;
            end
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            last_ld_v_r   <= 1'b0;
            last_ld_reg_r <= '0;
            trap_r        <= 1'b0;
        end else begin
            if (push_s) begin
                slots_r[wr_ptr_r] <= dec_s;
                wr_ptr_r          <= wr_ptr_r + PW'(1);
                last_ld_v_r       <= (dec_s.cls == CLS_LW) && dec_s.wr_en;
                last_ld_reg_r     <= dec_s.wr_reg;
                trap_r            <= trap_r || (dec_s.cls == CLS_ILL);
            end else begin
                trap_r            <= trap_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-slot view; stale contents when empty
    assign out_class    = slots_r[rd_ptr_r].cls;
    assign out_rs       = slots_r[rd_ptr_r].rs;
    assign out_rt       = slots_r[rd_ptr_r].rt;
    assign out_wr_reg   = slots_r[rd_ptr_r].wr_reg;
    assign out_wr_en    = slots_r[rd_ptr_r].wr_en;
    assign out_imm      = slots_r[rd_ptr_r].imm;
    assign out_funct    = slots_r[rd_ptr_r].funct;
    assign out_load_use = slots_r[rd_ptr_r].load_use;

endmodule
